etapa_mem_vectorial: RTL and testbench

Memory-stage sequencer that consumes the EXE/MEM pipeline register outputs and executes the access against a byte-wide synchronous data memory. Vector loads and stores run as four element accesses; scalar ones run as one. It stalls the upstream pipeline while busy and delivers a registered result plus write-back controls to the MEM/WB side.

---
 rtl/etapa_mem_vectorial_if.sv | 54 +++++
 rtl/etapa_mem_vectorial.sv | 176 +++++++++++++++++
 tb/tb_etapa_mem_vectorial.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/etapa_mem_vectorial_if.sv
// ============================================================================
// Module      : etapa_mem_vectorial_if
// Description : Bundles EXE/MEM inputs, stall, data-memory port and MEM/WB
//               outputs of the vector memory stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface etapa_mem_vectorial_if;
    logic        sel_pcmem_in;
    logic        sum_mem_in;
    logic        sel_mem_in;
    logic        sel_data_in;
    logic        mem_wr_in;
    logic        sel_wb_in;
    logic        reg_wrv_in;
    logic        reg_wrs_in;
    logic [31:0] DATA1_in;
    logic [31:0] ALU_in;
    logic [2:0]  dir_dest_in;
    logic [7:0]  inmediato_in;
    logic        stall;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic [7:0]  mem_rdata;
    logic        wb_valido;
    logic [31:0] wb_dato;
    logic [2:0]  wb_dir_dest;
    logic        wb_sel_wb;
    logic        wb_reg_wrv;
    logic        wb_reg_wrs;
    logic        wb_sel_pcmem;

    modport slave (
        input  sel_pcmem_in, sum_mem_in, sel_mem_in, sel_data_in, mem_wr_in,
        input  sel_wb_in, reg_wrv_in, reg_wrs_in, DATA1_in, ALU_in,
        input  dir_dest_in, inmediato_in, mem_rdata,
        output stall, mem_addr, mem_wdata, mem_we,
        output wb_valido, wb_dato, wb_dir_dest,
        output wb_sel_wb, wb_reg_wrv, wb_reg_wrs, wb_sel_pcmem
    );

    modport master (
        output sel_pcmem_in, sum_mem_in, sel_mem_in, sel_data_in, mem_wr_in,
        output sel_wb_in, reg_wrv_in, reg_wrs_in, DATA1_in, ALU_in,
        output dir_dest_in, inmediato_in, mem_rdata,
        input  stall, mem_addr, mem_wdata, mem_we,
        input  wb_valido, wb_dato, wb_dir_dest,
        input  wb_sel_wb, wb_reg_wrv, wb_reg_wrs, wb_sel_pcmem
    );
endinterface

`default_nettype wire

// File: rtl/etapa_mem_vectorial.sv
// ============================================================================
// Module      : etapa_mem_vectorial
// Description : Memory-stage sequencer; runs scalar (1) or vector (4) byte
//               accesses on a synchronous memory and stalls while busy.
//               Optional macro MEM_STRIDE_EN enables the immediate stride.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module etapa_mem_vectorial (
    input  logic                 clk,
    input  logic                 rst,
    etapa_mem_vectorial_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  addr_q, addr_d;
    logic [7:0]  stride_q, stride_d;
    logic        is_store_q, is_store_d;
    logic        is_vec_q, is_vec_d;
    logic [31:0] data1_q, data1_d;
    logic [31:0] alu_q, alu_d;
    logic [31:0] ld_q, ld_d;
    logic [2:0]  dest_q, dest_d;
    logic [3:0]  ctl_q, ctl_d;          // {sel_wb, reg_wrv, reg_wrs, sel_pcmem}
    logic        wb_valido_q, wb_valido_d;
    logic [31:0] wb_dato_q, wb_dato_d;
    logic [2:0]  wb_dir_dest_q, wb_dir_dest_d;
    logic [3:0]  wb_ctl_q, wb_ctl_d;

    logic        w_is_mem;
    logic        w_last;
    logic        w_ld_cap;
    logic [1:0]  w_lane;
    logic [7:0]  w_stride;
    logic [3:0]  w_ctl_in;

`ifdef MEM_STRIDE_EN
    assign w_stride = bus.sum_mem_in ? bus.inmediato_in : 8'd1;
`else
    logic w_unused_stride;
    assign w_unused_stride = ^{bus.sum_mem_in, bus.inmediato_in};
    assign w_stride        = 8'd1;
`endif

    assign w_is_mem = bus.sel_data_in | bus.mem_wr_in;
    assign w_last   = is_vec_q ? (idx_q == 3'd3) : 1'b1;
    assign w_ctl_in = {bus.sel_wb_in, bus.reg_wrv_in, bus.reg_wrs_in, bus.sel_pcmem_in};

    // Read data lags its request by one cycle, so it belongs to lane idx-1;
    // in FIN the index has already moved past the last element.
    assign w_lane   = idx_q[1:0] - 2'd1;
    assign w_ld_cap = ~is_store_q & (((state_q == ACC) & (idx_q != 3'd0)) | (state_q == FIN));

    assign bus.stall     = (state_q != IDLE);
    assign bus.mem_addr  = (state_q == ACC) ? addr_q : 8'd0;
    assign bus.mem_we    = (state_q == ACC) & is_store_q & ~rst;
    assign bus.mem_wdata = ((state_q == ACC) & is_store_q) ? data1_q[{idx_q[1:0], 3'b000} +: 8] : 8'd0;

    assign bus.wb_valido    = wb_valido_q;
    assign bus.wb_dato      = wb_dato_q;
    assign bus.wb_dir_dest  = wb_dir_dest_q;
    assign bus.wb_sel_wb    = wb_ctl_q[3];
    assign bus.wb_reg_wrv   = wb_ctl_q[2];
    assign bus.wb_reg_wrs   = wb_ctl_q[1];
    assign bus.wb_sel_pcmem = wb_ctl_q[0];

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        addr_d        = addr_q;
        stride_d      = stride_q;
        is_store_d    = is_store_q;
        is_vec_d      = is_vec_q;
        data1_d       = data1_q;
        alu_d         = alu_q;
        ld_d          = ld_q;
        dest_d        = dest_q;
        ctl_d         = ctl_q;
        wb_valido_d   = 1'b0;
        wb_dato_d     = wb_dato_q;
        wb_dir_dest_d = wb_dir_dest_q;
        wb_ctl_d      = wb_ctl_q;

        if (w_ld_cap) begin
            case (w_lane)
                2'd0:    ld_d[7:0]   = bus.mem_rdata;
                2'd1:    ld_d[15:8]  = bus.mem_rdata;
                2'd2:    ld_d[23:16] = bus.mem_rdata;
                default: ld_d[31:24] = bus.mem_rdata;
            endcase
        end

        case (state_q)
            IDLE: begin
                if (w_is_mem) begin
                    idx_d      = 3'd0;
                    addr_d     = bus.ALU_in[7:0];
                    stride_d   = w_stride;
                    is_store_d = bus.mem_wr_in;
                    is_vec_d   = bus.sel_mem_in;
                    data1_d    = bus.DATA1_in;
                    alu_d      = bus.ALU_in;
                    ld_d       = 32'd0;
                    dest_d     = bus.dir_dest_in;
                    ctl_d      = w_ctl_in;
                    state_d    = ACC;
                end else begin
                    wb_valido_d   = 1'b1;
                    wb_dato_d     = bus.ALU_in;
                    wb_dir_dest_d = bus.dir_dest_in;
                    wb_ctl_d      = w_ctl_in;
                end
            end
            ACC: begin
                idx_d  = idx_q + 3'd1;
                addr_d = addr_q + stride_q;
                if (w_last) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                wb_valido_d   = 1'b1;
                wb_dato_d     = is_store_q ? alu_q : ld_d;
                wb_dir_dest_d = dest_q;
                wb_ctl_d      = ctl_q;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            idx_q         <= 3'd0;
            addr_q        <= 8'd0;
            stride_q      <= 8'd0;
            is_store_q    <= 1'b0;
            is_vec_q      <= 1'b0;
            data1_q       <= 32'd0;
            alu_q         <= 32'd0;
            ld_q          <= 32'd0;
            dest_q        <= 3'd0;
            ctl_q         <= 4'd0;
            wb_valido_q   <= 1'b0;
            wb_dato_q     <= 32'd0;
            wb_dir_dest_q <= 3'd0;
            wb_ctl_q      <= 4'd0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            addr_q        <= addr_d;
            stride_q      <= stride_d;
            is_store_q    <= is_store_d;
            is_vec_q      <= is_vec_d;
            data1_q       <= data1_d;
            alu_q         <= alu_d;
            ld_q          <= ld_d;
            dest_q        <= dest_d;
            ctl_q         <= ctl_d;
            wb_valido_q   <= wb_valido_d;
            wb_dato_q     <= wb_dato_d;
            wb_dir_dest_q <= wb_dir_dest_d;
            wb_ctl_q      <= wb_ctl_d;
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_etapa_mem_vectorial.sv
// ============================================================================
// Module      : tb_etapa_mem_vectorial
// Description : Self-checking bench for etapa_mem_vectorial with a byte
//               memory model and an instruction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_etapa_mem_vectorial;
    typedef struct {
        logic        sel_pcmem, sum_mem, sel_mem, sel_data, mem_wr;
        logic        sel_wb, wrv, wrs;
        logic [31:0] data1, alu;
        logic [2:0]  dest;
        logic [7:0]  inm;
    } instr_t;

    typedef struct {
        logic        stall, we, v;
        logic [7:0]  addr, wdata;
        logic [31:0] dato;
        logic [2:0]  dest;
        logic [3:0]  ctl;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mem_init = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   stall_cnt = 0;
    int   we_cnt = 0;

    logic [7:0]  ram [256];
    logic [7:0]  ref_mem [256];
    exp_t        q [$];
    logic [31:0] m_dato = 32'd0;
    logic [2:0]  m_dest = 3'd0;
    logic [3:0]  m_ctl = 4'd0;

    etapa_mem_vectorial_if ifc ();

    etapa_mem_vectorial dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] init_val(input int i);
        case (i)
            8'h10:   return 8'h11;
            8'h11:   return 8'h22;
            8'h12:   return 8'h33;
            8'h13:   return 8'h44;
            8'h40:   return 8'h9C;
            default: return 8'(i * 7 + 3) ^ 8'h5A;
        endcase
    endfunction

    // Synchronous byte memory: read data appears one cycle after its address.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) ram[i] <= init_val(i);
            ifc.mem_rdata <= 8'd0;
        end else begin
            if (ifc.mem_we) ram[ifc.mem_addr] <= ifc.mem_wdata;
            ifc.mem_rdata <= ram[ifc.mem_addr];
        end
    end

    always @(posedge clk) begin
        if (ifc.stall)  stall_cnt <= stall_cnt + 1;
        if (ifc.mem_we) we_cnt <= we_cnt + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic exp_t cur(input logic s, input logic w, input logic [7:0] a,
                                 input logic [7:0] d, input logic v);
        exp_t e;
        e.stall = s; e.we = w; e.addr = a; e.wdata = d; e.v = v;
        e.dato = m_dato; e.dest = m_dest; e.ctl = m_ctl;
        return e;
    endfunction

    // Reference model: expands one instruction into its expected per-cycle outputs.
    task automatic push_instr(input instr_t in, input int n_commit, output int len);
        logic [7:0]  a, st;
        logic [31:0] ld;
        int          n;
        logic        is_st;
        is_st = in.mem_wr;
        if (!(in.mem_wr || in.sel_data)) begin
            m_dato = in.alu; m_dest = in.dest;
            m_ctl  = {in.sel_wb, in.wrv, in.wrs, in.sel_pcmem};
            q.push_back(cur(1'b0, 1'b0, 8'd0, 8'd0, 1'b1));
            len = 1;
            return;
        end
        n = in.sel_mem ? 4 : 1;
`ifdef MEM_STRIDE_EN
        st = in.sum_mem ? in.inm : 8'd1;
`else
        st = 8'd1;
`endif
        ld = 32'd0;
        for (int k = 0; k < n; k++) begin
            a = in.alu[7:0] + st * 8'(k);
            q.push_back(cur(1'b1, is_st, a, is_st ? in.data1[8*k +: 8] : 8'd0, 1'b0));
            if (is_st && k < n_commit) ref_mem[a] = in.data1[8*k +: 8];
            if (!is_st) ld[8*k +: 8] = ref_mem[a];
        end
        q.push_back(cur(1'b1, 1'b0, 8'd0, 8'd0, 1'b0));
        m_dato = is_st ? in.alu : ld; m_dest = in.dest;
        m_ctl  = {in.sel_wb, in.wrv, in.wrs, in.sel_pcmem};
        q.push_back(cur(1'b0, 1'b0, 8'd0, 8'd0, 1'b1));
        len = n + 2;
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (!rst) begin
            if (q.size() == 0) begin
                chk("model_queue_empty", 32'd0, 32'd1);
            end else begin
                e = q.pop_front();
                chk("stall",       ifc.stall,     e.stall);
                chk("mem_we",      ifc.mem_we,    e.we);
                chk("mem_addr",    ifc.mem_addr,  e.addr);
                chk("mem_wdata",   ifc.mem_wdata, e.wdata);
                chk("wb_valido",   ifc.wb_valido, e.v);
                chk("wb_dato",     ifc.wb_dato,   e.dato);
                chk("wb_dir_dest", ifc.wb_dir_dest, e.dest);
                chk("wb_ctl", {ifc.wb_sel_wb, ifc.wb_reg_wrv, ifc.wb_reg_wrs, ifc.wb_sel_pcmem}, e.ctl);
            end
        end
    end

    function automatic instr_t zero_instr();
        instr_t in;
        in.sel_pcmem = 0; in.sum_mem = 0; in.sel_mem = 0; in.sel_data = 0; in.mem_wr = 0;
        in.sel_wb = 0; in.wrv = 0; in.wrs = 0;
        in.data1 = 0; in.alu = 0; in.dest = 0; in.inm = 0;
        return in;
    endfunction

    function automatic instr_t rand_instr();
        instr_t in;
        int     kind;
        in = zero_instr();
        kind = $urandom_range(0, 3);
        in.sel_data = (kind == 1 || kind == 3);
        in.mem_wr   = (kind == 2 || kind == 3);
        if (kind != 0 || $urandom_range(0, 3) != 0) begin
            in.sel_pcmem = 1'($urandom); in.sum_mem = 1'($urandom);
            in.sel_mem = 1'($urandom); in.sel_wb = 1'($urandom);
            in.wrv = 1'($urandom); in.wrs = 1'($urandom);
            in.data1 = $urandom; in.alu = $urandom;
            in.dest = 3'($urandom); in.inm = 8'($urandom);
        end
        return in;
    endfunction

    task automatic drive(input instr_t in);
        ifc.sel_pcmem_in = in.sel_pcmem; ifc.sum_mem_in = in.sum_mem;
        ifc.sel_mem_in   = in.sel_mem;   ifc.sel_data_in = in.sel_data;
        ifc.mem_wr_in    = in.mem_wr;    ifc.sel_wb_in  = in.sel_wb;
        ifc.reg_wrv_in   = in.wrv;       ifc.reg_wrs_in = in.wrs;
        ifc.DATA1_in     = in.data1;     ifc.ALU_in     = in.alu;
        ifc.dir_dest_in  = in.dest;      ifc.inmediato_in = in.inm;
    endtask

    // Inputs change on the negedge; unrelated values are driven while stalled.
    task automatic issue(input instr_t in);
        int len;
        drive(in);
        push_instr(in, 4, len);
        for (int c = 1; c < len; c++) begin
            @(negedge clk);
            drive(rand_instr());
        end
        @(negedge clk);
    endtask

    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog_timeout t=%0t", $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    initial begin
        instr_t in;
        int     s0, w0, len;
        logic [31:0] st_data;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
        drive(zero_instr());
        repeat (3) @(negedge clk);
        mem_init = 1'b0;
        chk("rst_stall", ifc.stall, 1'b0);
        chk("rst_mem_we", ifc.mem_we, 1'b0);
        chk("rst_mem_addr", ifc.mem_addr, 8'd0);
        chk("rst_mem_wdata", ifc.mem_wdata, 8'd0);
        chk("rst_wb_valido", ifc.wb_valido, 1'b0);
        chk("rst_wb_dato", ifc.wb_dato, 32'd0);
        chk("rst_wb_ctl", {ifc.wb_dir_dest, ifc.wb_sel_wb, ifc.wb_reg_wrv, ifc.wb_reg_wrs, ifc.wb_sel_pcmem}, 7'd0);
        rst = 1'b0;

        // Vector load from 0x10
        in = zero_instr(); in.alu = 32'h10; in.sel_mem = 1; in.sel_data = 1; in.wrv = 1; in.dest = 3'd5;
        s0 = stall_cnt;
        issue(in);
        chk("vload_dato", ifc.wb_dato, 32'h44332211);
        chk("vload_dest", ifc.wb_dir_dest, 3'd5);
        chk("vload_wrv", ifc.wb_reg_wrv, 1'b1);
        chk("vload_valido", ifc.wb_valido, 1'b1);
        chk("vload_stall_cycles", stall_cnt - s0, 5);

        // Strided vector store wrapping past 0xFF
        in = zero_instr(); in.alu = 32'hFE; in.inm = 8'd4; in.sum_mem = 1; in.sel_mem = 1;
        in.mem_wr = 1; in.data1 = 32'hA1B2C3D4;
        w0 = we_cnt;
        issue(in);
        chk("vstore_we_cycles", we_cnt - w0, 4);
        chk("vstore_dato", ifc.wb_dato, 32'hFE);
        chk("vstore_b0", ram[8'hFE], 8'hD4);
`ifdef MEM_STRIDE_EN
        chk("vstore_b1", ram[8'h02], 8'hC3);
        chk("vstore_b2", ram[8'h06], 8'hB2);
        chk("vstore_b3", ram[8'h0A], 8'hA1);
`else
        chk("vstore_b1", ram[8'hFF], 8'hC3);
        chk("vstore_b2", ram[8'h00], 8'hB2);
        chk("vstore_b3", ram[8'h01], 8'hA1);
`endif

        // Two back-to-back passthroughs
        in = zero_instr(); in.alu = 32'hDEADBEEF; in.wrs = 1;
        s0 = stall_cnt;
        issue(in);
        chk("pass1_dato", ifc.wb_dato, 32'hDEADBEEF);
        chk("pass1_valido", ifc.wb_valido, 1'b1);
        chk("pass1_wrs", ifc.wb_reg_wrs, 1'b1);
        in.alu = 32'h12345678;
        issue(in);
        chk("pass2_dato", ifc.wb_dato, 32'h12345678);
        chk("pass2_valido", ifc.wb_valido, 1'b1);
        chk("pass_stall_cycles", stall_cnt - s0, 0);

        // Scalar load, zero-extended
        in = zero_instr(); in.alu = 32'h40; in.sel_data = 1;
        s0 = stall_cnt;
        issue(in);
        chk("sload_dato", ifc.wb_dato, 32'h0000009C);
        chk("sload_stall_cycles", stall_cnt - s0, 2);

        // Reset during the third ACC cycle of a vector store at 0x80
        st_data = 32'hCAFE5A3C;
        in = zero_instr(); in.alu = 32'h80; in.sel_mem = 1; in.mem_wr = 1; in.data1 = st_data;
        drive(in);
        push_instr(in, 2, len);
        @(negedge clk); drive(rand_instr());
        @(negedge clk); drive(rand_instr());
        @(negedge clk);
        rst = 1'b1;
        q.delete();
        #1;
        chk("abort_we_gated", ifc.mem_we, 1'b0);
        @(posedge clk); #1;
        chk("abort_stall", ifc.stall, 1'b0);
        chk("abort_valido", ifc.wb_valido, 1'b0);
        chk("abort_wb_dato", ifc.wb_dato, 32'd0);
        @(negedge clk);
        chk("abort_b1_kept", ram[8'h81], st_data[15:8]);
        chk("abort_b2_suppressed", ram[8'h82], ref_mem[8'h82]);
        m_dato = 32'd0; m_dest = 3'd0; m_ctl = 4'd0;
        rst = 1'b0;
        in = zero_instr(); in.alu = 32'h80; in.sel_mem = 1; in.sel_data = 1; in.wrv = 1;
        issue(in);
        chk("post_abort_load", ifc.wb_dato,
            {ref_mem[8'h83], ref_mem[8'h82], st_data[15:8], st_data[7:0]});

        // Randomized traffic
        for (int n = 0; n < 400; n++) issue(rand_instr());

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

`default_nettype wire
